// File: rtl/user_obi_timer_pkg.sv
// Package for the user-domain timer slice.
// Holds the OBI request/response types used by the user domain, the user demux
// address map entry for the timer, the register offsets and the CTRL layout,
// plus a byte-enable merge helper shared by the register file.
package user_obi_timer_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 4;

    typedef struct packed {
        logic                      req;
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } obi_req_t;

    typedef struct packed {
        logic                    gnt;
        logic                    rvalid;
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } obi_rsp_t;

    // Base of the user domain window in the SoC memory map.
    localparam logic [31:0] UserBaseAddr = 32'h2000_0000;

    localparam int unsigned NumUserDomainSubordinates = 1;

    // Demux output 0 is the error subordinate; the timer sits on output 1.
    typedef enum int unsigned {
        UserError = 0,
        UserTimer = 1
    } user_demux_outputs_e;

    localparam logic [31:0] UserTimerAddrOffset = UserBaseAddr;
    localparam logic [31:0] UserTimerAddrRange  = 32'h1000;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
        '{idx:        32'(UserTimer),
          start_addr: UserTimerAddrOffset,
          end_addr:   UserTimerAddrOffset + UserTimerAddrRange}
    };

    // Word indices decoded from addr[11:2].
    localparam logic [9:0] RegCtrl   = 10'h0;
    localparam logic [9:0] RegPresc  = 10'h1;
    localparam logic [9:0] RegCount  = 10'h2;
    localparam logic [9:0] RegCmp    = 10'h3;
    localparam logic [9:0] RegStatus = 10'h4;

    typedef struct packed {
        logic irqen;
        logic autoreload;
        logic en;
    } ctrl_reg_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] apply_be(logic [31:0] old_val, logic [31:0] wdata,
                                             logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_obi_timer_core.sv
// Timer core: prescaler, 32-bit up-counter, compare and MATCH flag.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   en_i, autoreload_i, irqen_i   CTRL fields
//   presc_i            prescaler reload value (tick every presc_i+1 cycles)
//   cmp_i              compare value
//   presc_we_i         PRESC written this cycle (restarts the prescaler)
//   count_we_i/count_wdata_i   software COUNT load (already byte-merged)
//   match_clr_i        W1C clear of MATCH
//   count_o, match_o, irq_o    counter value, MATCH flag, level interrupt
module user_obi_timer_core #(
    parameter int unsigned PrescWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  autoreload_i,
    input  logic                  irqen_i,
    input  logic [PrescWidth-1:0] presc_i,
    input  logic [31:0]           cmp_i,
    input  logic                  presc_we_i,
    input  logic                  count_we_i,
    input  logic [31:0]           count_wdata_i,
    input  logic                  match_clr_i,
    output logic [31:0]           count_o,
    output logic                  match_o,
    output logic                  irq_o
);

    logic [PrescWidth-1:0] pcnt_q, pcnt_d;
    logic [31:0]           count_q, count_d;
    logic                  match_q, match_d;
    logic                  tick, hit;

    always_comb begin
        tick = en_i && (pcnt_q == presc_i);
        hit  = (count_q == cmp_i);

        pcnt_d = pcnt_q + PrescWidth'(1);
        if (!en_i || presc_we_i || tick) begin
            pcnt_d = '0;
        end

        // Software load has priority over the tick update.
        count_d = count_q;
        if (count_we_i) begin
            count_d = count_wdata_i;
        end else if (tick) begin
            count_d = (hit && autoreload_i) ? 32'd0 : count_q + 32'd1;
        end

        // A new match wins over a simultaneous clear so the event is not lost.
        match_d = match_q;
        if (tick && hit) begin
            match_d = 1'b1;
        end else if (match_clr_i) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            match_q <= match_d;
        end
    end

    assign count_o = count_q;
    assign match_o = match_q;
    assign irq_o   = match_q & irqen_i;

endmodule

// File: rtl/user_obi_timer.sv
// OBI subordinate for the user-domain timer.
// Decodes the 4 KiB window, holds CTRL/PRESC/CMP, forwards COUNT/STATUS
// accesses to the timer core and returns a registered response one cycle
// after each grant. Unmapped offsets answer with err=1 and rdata=0.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   obi_req_i  OBI A-channel (req, addr, we, be, wdata, aid)
//   obi_rsp_o  OBI R-channel (gnt, rvalid, rdata, rid, err)
//   irq_o      level interrupt, MATCH & IRQEN
module user_obi_timer
    import user_obi_timer_pkg::*;
#(
    parameter int unsigned PrescWidth = 16
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    ctrl_reg_t             ctrl_q;
    logic [PrescWidth-1:0] presc_q;
    logic [31:0]           cmp_q;

    logic                  rvalid_q, err_q;
    logic [31:0]           rdata_q;
    logic [ObiIdWidth-1:0] rid_q;

    logic [9:0]  reg_idx;
    logic        addr_hit;
    logic [31:0] rdata_d;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic [31:0] presc_wval, count_wval, count_val;
    logic        match_val;

    assign reg_idx = obi_req_i.addr[11:2];

    always_comb begin
        addr_hit = 1'b1;
        rdata_d  = '0;
        case (reg_idx)
            RegCtrl:   rdata_d = {29'd0, ctrl_q};
            RegPresc:  rdata_d = 32'(presc_q);
            RegCount:  rdata_d = count_val;
            RegCmp:    rdata_d = cmp_q;
            RegStatus: rdata_d = {31'd0, match_val};
            default:   addr_hit = 1'b0;
        endcase
    end

    always_comb begin
        wr_ctrl   = 1'b0;
        wr_presc  = 1'b0;
        wr_count  = 1'b0;
        wr_cmp    = 1'b0;
        wr_status = 1'b0;
        if (obi_req_i.req && obi_req_i.we) begin
            wr_ctrl   = (reg_idx == RegCtrl);
            wr_presc  = (reg_idx == RegPresc);
            wr_count  = (reg_idx == RegCount);
            wr_cmp    = (reg_idx == RegCmp);
            wr_status = (reg_idx == RegStatus);
        end
    end

    assign presc_wval = apply_be(32'(presc_q), obi_req_i.wdata, obi_req_i.be);
    assign count_wval = apply_be(count_val, obi_req_i.wdata, obi_req_i.be);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            presc_q  <= '0;
            cmp_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            // CTRL lives entirely in byte 0.
            if (wr_ctrl && obi_req_i.be[0]) begin
                ctrl_q <= ctrl_reg_t'(obi_req_i.wdata[2:0]);
            end
            if (wr_presc) begin
                presc_q <= presc_wval[PrescWidth-1:0];
            end
            if (wr_cmp) begin
                cmp_q <= apply_be(cmp_q, obi_req_i.wdata, obi_req_i.be);
            end
            rvalid_q <= obi_req_i.req;
            err_q    <= obi_req_i.req & ~addr_hit;
            rdata_q  <= (obi_req_i.req && !obi_req_i.we) ? rdata_d : 32'd0;
            if (obi_req_i.req) begin
                rid_q <= obi_req_i.aid;
            end
        end
    end

    user_obi_timer_core #(
        .PrescWidth (PrescWidth)
    ) u_core (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (ctrl_q.en),
        .autoreload_i  (ctrl_q.autoreload),
        .irqen_i       (ctrl_q.irqen),
        .presc_i       (presc_q),
        .cmp_i         (cmp_q),
        .presc_we_i    (wr_presc),
        .count_we_i    (wr_count),
        .count_wdata_i (count_wval),
        .match_clr_i   (wr_status & obi_req_i.be[0] & obi_req_i.wdata[0]),
        .count_o       (count_val),
        .match_o       (match_val),
        .irq_o         (irq_o)
    );

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.rid    = rid_q;
        obi_rsp_o.err    = err_q;
    end

    // Address bits outside the word index and the upper PRESC merge bits are unused.
    logic unused_bits;
    assign unused_bits = ^{obi_req_i.addr[31:12], obi_req_i.addr[1:0],
                           presc_wval[31:PrescWidth]};

endmodule

// File: tb/tb_user_obi_timer.sv
// Self-checking bench for user_obi_timer: directed vector table, hand-written
// timing sequences and a randomized run against a cycle-level reference model.
module tb_user_obi_timer;
    import user_obi_timer_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    obi_req_t req;
    obi_rsp_t rsp;
    logic     irq;

    always #5 clk = ~clk;

    user_obi_timer #(
        .PrescWidth (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .irq_o     (irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc, m_pcnt;
    logic [31:0] m_count, m_cmp, m_rdata;
    logic        m_match, m_rvalid, m_err;
    logic [3:0]  m_rid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (o & ~m) | (w & m);
    endfunction

    // Advance the model by one clock edge using the inputs just sampled.
    task automatic model_step();
        int          off;
        bit          valid, wr, tick, hit;
        logic [31:0] rv, tmp;
        logic [15:0] n_pcnt;
        logic [31:0] n_count;
        logic        n_match;
        if (rst) begin
            m_ctrl = 0; m_presc = 0; m_pcnt = 0; m_count = 0; m_cmp = 0; m_match = 0;
            m_rvalid = 0; m_rdata = 0; m_err = 0; m_rid = 0;
            return;
        end
        off   = int'(req.addr[11:2]);
        valid = (off < 5);
        wr    = req.req && req.we && valid;
        rv    = 0;
        if (req.req && !req.we && valid) begin
            case (off)
                0: rv = {29'd0, m_ctrl};
                1: rv = {16'd0, m_presc};
                2: rv = m_count;
                3: rv = m_cmp;
                default: rv = {31'd0, m_match};
            endcase
        end
        tick = m_ctrl[0] && (m_pcnt == m_presc);
        hit  = (m_count == m_cmp);

        n_pcnt = (!m_ctrl[0] || (wr && off == 1) || tick) ? 16'd0 : m_pcnt + 16'd1;
        n_count = m_count;
        if (tick) n_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        if (wr && off == 2) n_count = merge(m_count, req.wdata, req.be);
        n_match = m_match;
        if (wr && off == 4 && req.be[0] && req.wdata[0]) n_match = 1'b0;
        if (tick && hit) n_match = 1'b1;

        if (wr && off == 0) begin
            tmp = merge({29'd0, m_ctrl}, req.wdata, req.be);
            m_ctrl = tmp[2:0];
        end
        if (wr && off == 1) begin
            tmp = merge({16'd0, m_presc}, req.wdata, req.be);
            m_presc = tmp[15:0];
        end
        if (wr && off == 3) m_cmp = merge(m_cmp, req.wdata, req.be);
        m_pcnt   = n_pcnt;
        m_count  = n_count;
        m_match  = n_match;
        m_rvalid = req.req;
        m_err    = req.req && !valid;
        m_rdata  = rv;
        if (req.req) m_rid = req.aid;
    endtask

    // One clock cycle: drive, check gnt, step the model, compare all outputs.
    task automatic bus(input bit r, input bit w, input logic [11:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [3:0] id, input bit rs);
        logic g;
        @(negedge clk);
        rst       = rs;
        req.req   = r;
        req.we    = w;
        req.addr  = {20'h20000, a};
        req.be    = b;
        req.wdata = d;
        req.aid   = id;
        #1;
        g = rsp.gnt;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("model", {g, rsp.rvalid, rsp.err, rsp.rid, rsp.rdata, irq},
              {r, m_rvalid, m_err, m_rid, m_rdata, m_ctrl[2] & m_match});
    endtask

    task automatic idle();
        bus(0, 0, 12'h0, 4'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic wr32(input logic [11:0] a, input logic [31:0] d);
        bus(1, 1, a, 4'hF, d, 4'h0, 0);
    endtask

    task automatic rd32(input logic [11:0] a);
        bus(1, 0, a, 4'hF, 32'h0, 4'h0, 0);
    endtask

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit we, input logic [11:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic [3:0] id,
                           input logic [31:0] er, input bit ee);
        vec_t v;
        v = '{we, a, b, d, id, er, ee};
        vecs.push_back(v);
    endtask

    initial begin
        int start, c1, c2;
        logic [9:0]  off;
        logic [31:0] d;

        rst = 1'b1;
        req = '0;

        // Reset for two cycles, then all registers read 0.
        bus(0, 0, 12'h0, 4'h0, 32'h0, 4'h0, 1);
        bus(0, 0, 12'h0, 4'h0, 32'h0, 4'h0, 1);
        check("reset_rvalid", {63'd0, rsp.rvalid}, 64'd0);
        check("reset_irq", {63'd0, irq}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            rd32(12'(i * 4));
            check($sformatf("reset_read_%0d", i), {32'd0, rsp.rdata}, 64'd0);
        end

        // Directed register vectors (timer disabled, so values are static).
        add_vec(1, 12'h00C, 4'hF, 32'h0000_0000, 4'd0, 32'h0, 0);
        add_vec(1, 12'h00C, 4'h2, 32'hAABB_CCDD, 4'd1, 32'h0, 0);
        add_vec(0, 12'h00C, 4'hF, 32'h0,         4'd2, 32'h0000_CC00, 0);
        add_vec(1, 12'h004, 4'hF, 32'h1234_5678, 4'd3, 32'h0, 0);
        add_vec(0, 12'h004, 4'hF, 32'h0,         4'd4, 32'h0000_5678, 0);
        add_vec(1, 12'h000, 4'hF, 32'hFFFF_FFF8, 4'd5, 32'h0, 0);
        add_vec(0, 12'h000, 4'hF, 32'h0,         4'd6, 32'h0, 0);
        add_vec(1, 12'h000, 4'h1, 32'h0000_0006, 4'd7, 32'h0, 0);
        add_vec(0, 12'h000, 4'hF, 32'h0,         4'd8, 32'h6, 0);
        add_vec(1, 12'h008, 4'h0, 32'h1122_3344, 4'd9, 32'h0, 0);
        add_vec(0, 12'h008, 4'hF, 32'h0,         4'd10, 32'h0, 0);
        add_vec(1, 12'h008, 4'hC, 32'h1122_3344, 4'd11, 32'h0, 0);
        add_vec(0, 12'h008, 4'hF, 32'h0,         4'd12, 32'h1122_0000, 0);
        add_vec(0, 12'h020, 4'hF, 32'h0,         4'd1, 32'h0, 1);
        add_vec(0, 12'h024, 4'hF, 32'h0,         4'd2, 32'h0, 1);
        add_vec(1, 12'h014, 4'hF, 32'hFFFF_FFFF, 4'd3, 32'h0, 1);
        add_vec(0, 12'h010, 4'hF, 32'h0,         4'd4, 32'h0, 0);
        add_vec(1, 12'h008, 4'hF, 32'h0,         4'd5, 32'h0, 0);
        add_vec(1, 12'h000, 4'hF, 32'h0,         4'd6, 32'h0, 0);
        foreach (vecs[i]) begin
            bus(1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].aid, 0);
            check($sformatf("vec%0d_resp", i), {26'd0, rsp.rvalid, rsp.err, rsp.rid, rsp.rdata},
                  {26'd0, 1'b1, vecs[i].exp_err, vecs[i].aid, vecs[i].exp_rdata});
        end

        // Reset in the same cycle as a request: no response.
        bus(1, 0, 12'h008, 4'hF, 32'h0, 4'd9, 1);
        check("reset_drops_rvalid", {63'd0, rsp.rvalid}, 64'd0);

        // Ticking: PRESC=3, CMP=2, EN|AUTORELOAD|IRQEN -> match 12 cycles later.
        wr32(12'h004, 32'd3);
        wr32(12'h00C, 32'd2);
        wr32(12'h000, 32'd7);
        start = cyc;
        for (int i = 0; i < 40 && !irq; i++) idle();
        check("tick_latency", 64'(cyc - start), 64'd12);
        c1 = cyc;
        rd32(12'h008);
        check("count_after_reload", {32'd0, rsp.rdata}, 64'd0);

        // W1C clears irq; auto-reload re-triggers 12 cycles after the first match.
        bus(1, 1, 12'h010, 4'h1, 32'h1, 4'h0, 0);
        check("w1c_clears_irq", {63'd0, irq}, 64'd0);
        for (int i = 0; i < 40 && !irq; i++) idle();
        check("retrigger_period", 64'(cyc - c1), 64'd12);
        c2 = cyc;

        // Collision: W1C lands on the same edge as the next match.
        bus(1, 1, 12'h010, 4'h1, 32'h1, 4'h0, 0);
        check("collision_pre_clear", {63'd0, irq}, 64'd0);
        while (cyc < c2 + 11) idle();
        bus(1, 1, 12'h010, 4'h1, 32'h1, 4'h0, 0);
        check("collision_irq_kept", {63'd0, irq}, 64'd1);
        rd32(12'h010);
        check("collision_status", {32'd0, rsp.rdata}, 64'd1);

        // Counter wrap with PRESC=0.
        wr32(12'h000, 32'd0);
        wr32(12'h004, 32'd0);
        wr32(12'h008, 32'hFFFF_FFFF);
        wr32(12'h00C, 32'd5);
        wr32(12'h000, 32'd1);
        rd32(12'h008);
        check("wrap_before", {32'd0, rsp.rdata}, {32'd0, 32'hFFFF_FFFF});
        rd32(12'h008);
        check("wrap_after", {32'd0, rsp.rdata}, 64'd0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            off = 10'($urandom_range(0, 7));
            case (off)
                10'd1:       d = $urandom_range(0, 3);
                10'd2, 10'd3: d = $urandom_range(0, 6);
                default:     d = $urandom;
            endcase
            bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), {off, 2'b00},
                4'($urandom_range(0, 15)), d, 4'($urandom_range(0, 15)),
                $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
